// File: rtl/cache_pkg.sv
// Shared constants and width helpers for the 2-way set-associative cache.
package cache_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    function automatic int line_width(input int word_w, input int offset_w);
        return word_w << offset_w;
    endfunction

    function automatic int addr_width(input int tag_w, input int index_w);
        return tag_w + index_w;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag/valid/dirty state per set plus line data, with a
// combinational lookup port and mutually exclusive write-hit / fill ports.
module cache_way import cache_pkg::*; #(
    parameter  int WORD_W   = 32,
    parameter  int OFFSET_W = 1,
    parameter  int INDEX_W  = 2,
    parameter  int TAG_W    = 3,
    localparam int LINE_W   = line_width(WORD_W, OFFSET_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic                match_o,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [WORD_W-1:0]   word_o,
    output logic [LINE_W-1:0]   line_o,
    input  logic                wr_en_i,
    input  logic [WORD_W-1:0]   wr_data_i,
    input  logic                fill_en_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [LINE_W-1:0]   fill_line_i
);

    localparam int WORDS = 1 << OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;

    logic [WORDS-1:0][WORD_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]             tag_q  [SETS];
    logic [SETS-1:0]              valid_q;
    logic [SETS-1:0]              dirty_q;

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign match_o = valid_q[index_i] && (tag_q[index_i] == tag_i);
    assign word_o  = data_q[index_i][offset_i];
    assign line_o  = data_q[index_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[index_i]  <= fill_tag_i;
            data_q[index_i] <= fill_line_i;
        end else if (wr_en_i) begin
            data_q[index_i][offset_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative write-back, write-allocate cache controller with
// per-set LRU, dirty victim write-back and line-wide memory handshake.
module assoc_cache_ctrl import cache_pkg::*; #(
    parameter  int WORD_W   = 32,
    parameter  int OFFSET_W = 1,
    parameter  int INDEX_W  = 2,
    parameter  int TAG_W    = 3,
    localparam int LINE_W   = line_width(WORD_W, OFFSET_W),
    localparam int ADDR_W   = addr_width(TAG_W, INDEX_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_req,
    input  logic                write_req,
    input  logic [TAG_W-1:0]    tag,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [WORD_W-1:0]   wr_data,
    output logic [WORD_W-1:0]   rd_data,
    output logic                hit,
    output logic                stall,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wr_line,
    input  logic [LINE_W-1:0]   mem_rd_line,
    input  logic                mem_done
);

    localparam int SETS = 1 << INDEX_W;

    logic [1:0]         state_q, state_d;
    logic               victim_q, victim_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_index_q, miss_index_d;
    logic [SETS-1:0]    lru_q, lru_d;

    logic [1:0]         way_match, way_valid, way_dirty, way_wr_en, way_fill_en;
    logic [TAG_W-1:0]   way_tag  [2];
    logic [WORD_W-1:0]  way_word [2];
    logic [LINE_W-1:0]  way_line [2];
    logic [INDEX_W-1:0] way_index;

    logic is_idle, req, hit_way, fill_done, pick;

    assign is_idle = (state_q == ST_IDLE);
    assign req     = read_req | write_req;
    // Outside IDLE the request inputs may drop, so the ways follow the latched miss set.
    assign way_index = is_idle ? index : miss_index_q;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .WORD_W  (WORD_W),
            .OFFSET_W(OFFSET_W),
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W)
        ) u_way (
            .clk        (clk),
            .reset      (reset),
            .index_i    (way_index),
            .tag_i      (tag),
            .offset_i   (offset),
            .match_o    (way_match[w]),
            .valid_o    (way_valid[w]),
            .dirty_o    (way_dirty[w]),
            .tag_o      (way_tag[w]),
            .word_o     (way_word[w]),
            .line_o     (way_line[w]),
            .wr_en_i    (way_wr_en[w]),
            .wr_data_i  (wr_data),
            .fill_en_i  (way_fill_en[w]),
            .fill_tag_i (miss_tag_q),
            .fill_line_i(mem_rd_line)
        );
    end

    assign hit     = is_idle & req & (|way_match);
    assign hit_way = ~way_match[0];
    assign stall   = ~is_idle | (req & ~hit);
    assign rd_data = (hit & read_req & ~write_req) ? way_word[hit_way] : '0;

    assign way_wr_en[0] = hit & write_req & way_match[0] & ~reset;
    assign way_wr_en[1] = hit & write_req & ~way_match[0] & ~reset;

    assign fill_done      = (state_q == ST_FILL) & mem_done & ~reset;
    assign way_fill_en[0] = fill_done & ~victim_q;
    assign way_fill_en[1] = fill_done & victim_q;

    assign mem_rd_req  = (state_q == ST_FILL);
    assign mem_wr_req  = (state_q == ST_WRITEBACK);
    assign mem_wr_line = mem_wr_req ? way_line[victim_q] : '0;

    always_comb begin
        mem_addr = '0;
        if (mem_wr_req) begin
            mem_addr = {way_tag[victim_q], miss_index_q};
        end else if (mem_rd_req) begin
            mem_addr = {miss_tag_q, miss_index_q};
        end
    end

    // Invalid ways are preferred (way 0 first); otherwise the LRU bit names the victim.
    assign pick = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : lru_q[index]);

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        lru_d        = lru_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    lru_d[index] = way_match[0];
                end else if (req) begin
                    victim_d     = pick;
                    miss_tag_d   = tag;
                    miss_index_d = index;
                    state_d      = (way_valid[pick] & way_dirty[pick]) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_done) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (mem_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            victim_q     <= 1'b0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            lru_q        <= lru_d;
        end
    end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
Parametrised 2-way set-associative, write-back, write-allocate cache controller; successor to the direct-mapped, read-only-fill cache. Sits between the processor load/store path and the main-memory model. Adds configurable word/line/set/tag widths, per-set LRU replacement, dirty tracking and victim write-back over a line-wide memory handshake.

Parameters:
WORD_W, 32, data word width
OFFSET_W, 1, log2(words per line); LINE_W = WORD_W << OFFSET_W
INDEX_W, 2, log2(sets)
TAG_W, 3, tag width; memory line address = {tag, index}

Ports:
clk  in  1  clock; single domain
reset  in  1  synchronous, active-high reset
read_req  in  1  processor read; held stable while stall=1
write_req  in  1  processor write; held stable while stall=1
tag  in  TAG_W  request tag
index  in  INDEX_W  request set
offset  in  OFFSET_W  word within line
wr_data  in  WORD_W  store data
rd_data  out  WORD_W  load data; valid when hit=1 and read
hit  out  1  request hits in IDLE (combinational)
stall  out  1  request pending and not hit, or FSM not IDLE
mem_rd_req  out  1  line fill request, level, held until mem_done
mem_wr_req  out  1  victim write-back request, level, held until mem_done
mem_addr  out  TAG_W+INDEX_W  line address for current memory request
mem_wr_line  out  LINE_W  victim line; word 0 in bits [WORD_W-1:0]
mem_rd_line  in  LINE_W  fill line; sampled on the cycle mem_done=1
mem_done  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (sync, active-high): all valid, dirty, LRU bits cleared; FSM to IDLE. Outputs: rd_data=0, hit=0, stall=0, mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wr_line=0. Reset mid-WRITEBACK/FILL aborts; requests drop the cycle after the reset edge; in-flight mem_done ignored.
- Request = read_req | write_req. Both asserted: treated as write; rd_data=0.
- IDLE lookup, combinational: hit = request & valid & tag-match in either way. Read hit: rd_data = word[offset], zero latency, stall=0. Write hit: word[offset] <= wr_data and dirty <= 1 at the clock edge. Any hit sets LRU[index] to point at the other way at the edge. No request, or a miss: rd_data=0.
- Miss in IDLE: stall=1 in the same cycle. Victim: first invalid way (way 0 before way 1), else way LRU[index]. The victim way is registered at the edge. Next state: WRITEBACK if victim valid & dirty, else FILL.
- WRITEBACK: mem_wr_req=1, mem_addr={victim tag, index}, mem_wr_line=victim line. On mem_done go to FILL.
- FILL: mem_rd_req=1, mem_addr={tag, index}. On mem_done: victim data <= mem_rd_line, tag written, valid=1, dirty=0; go to IDLE. The fill does not write wr_data; the held request re-hits in IDLE on the next cycle, where a write merges and sets dirty.
- stall=1 throughout WRITEBACK and FILL. mem_rd_req and mem_wr_req are never both 1. mem_done outside WRITEBACK/FILL is ignored.
- Miss latency: 1 (IDLE) + fill cycles (+ write-back cycles when dirty); the hit follows the cycle after the final mem_done.
- Request dropped mid-miss: the in-progress write-back/fill completes; FSM returns to IDLE with no processor write.

Decomposition:
- Package cache_pkg: state enum {IDLE, WRITEBACK, FILL}; LINE_W and address-width helper functions.
- Sub-module cache_way: one way's tag/valid/dirty/data arrays with lookup/match output and write/fill ports, instantiated twice. Controller holds the FSM and LRU.

Test Plan:
- Cold read miss: reset, read tag0/idx0/off1 -> stall=1, mem_rd_req=1, mem_addr=0; mem_done after 20 cycles with line {FFFFAAAA, AAAAFFFF} -> next cycle hit=1, rd_data=FFFFAAAA, stall=0.
- Write hit: write tag0/idx0/off0 data 12345678 -> hit=1, no memory request; read off0 -> rd_data=12345678.
- Fill second way: read tag1/idx0 -> fill into way 1 with no write-back.
- LRU dirty eviction: read tag1/idx0, then read tag2/idx0 -> mem_wr_req=1, mem_addr=0, mem_wr_line={FFFFAAAA, 12345678}; mem_done -> mem_rd_req addr=2'b10_00.
- Reset during FILL: after reset, mem_rd_req=0 and stall=0; a prior line no longer hits.
- Simultaneous read/write to a hit line -> write performed, rd_data=0; a stray mem_done in IDLE changes no state.
